dphy_lane_sequencer: RTL and testbench
======================================

# dphy_lane_sequencer

- Byte-clock-domain sequencer that feeds the single-lane D-PHY HS transmitter.
- Accepts one DSI packet at a time as a byte stream over a valid/ready handshake.
- Drives the clock-lane and data-lane LP states and the HS enables in the order the lanes need.
- Emits, on `byte_D0`: HS-zero, the 0xB8 sync byte, the payload, and HS-trail.
- Its outputs connect directly to the transmitter's `byte_D0`, `hs_clk_en`, `hsxx_clk_en`, `hs_data_en`, `lp0_out` and `lpclk_out` inputs.

## Interface
Parameters are in byte_clk cycles; each must be ≥1.
- T_LPX, 2: LP-01 duration, and the LP-11 exit guard.
- T_HS_PREP, 2: LP-00 duration before HS (clock and data).
- T_CLK_ZERO, 8: clock HS-0 duration, with hsxx_clk_en low.
- T_CLK_PRE, 2: toggling clock before the data lane leaves LP.
- T_HS_ZERO, 6: data HS-0 bytes before sync.
- T_HS_TRAIL, 4: data trail bytes.
- T_CLK_POST, 4: toggling clock after data returns to LP.
- T_CLK_TRAIL, 2: clock HS-0 before the clock lane returns to LP.

Ports:
- byte_clk  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- s_valid  in  1  payload byte valid.
- s_data  in  8  payload byte, LSB transmitted first.
- s_last  in  1  marks the final byte of the packet.
- s_ready  out  1  byte accepted when s_valid&s_ready at a rising edge.
- byte_D0  out  8  HS byte to the serializer.
- hs_data_en  out  1  data lane in HS.
- hs_clk_en  out  1  clock lane in HS.
- hsxx_clk_en  out  1  clock toggling (low = static HS-0).
- lp0_out  out  2  data lane LP {P,N}.
- lpclk_out  out  2  clock lane LP {P,N}.
- busy  out  1  state ≠ IDLE.
- err_underflow  out  1  one-cycle pulse on payload underflow.

## Operation
- One FSM with a shared down-counter.
  - On entry to each timed state the counter loads the parameter minus 1; the FSM advances when the counter is 0.
  - Each timed state therefore lasts exactly its parameter.
- State sequence: IDLE → CLK_LPX(T_LPX) → CLK_PREP(T_HS_PREP) → CLK_ZERO(T_CLK_ZERO) → CLK_PRE(T_CLK_PRE) → D_LPX(T_LPX) → D_PREP(T_HS_PREP) → D_ZERO(T_HS_ZERO) → SYNC(1) → DATA → TRAIL(T_HS_TRAIL) → CLK_POST(T_CLK_POST) → CLK_TRAIL(T_CLK_TRAIL) → EXIT(T_LPX) → IDLE.
- IDLE → CLK_LPX on s_valid=1. s_ready is 0 in IDLE; the first byte is held, not consumed.
- All outputs are registered and reflect the current state.
- lpclk_out:
  - 11 in IDLE and EXIT.
  - 01 in CLK_LPX.
  - 00 from CLK_PREP through CLK_TRAIL.
- lp0_out:
  - 01 in D_LPX.
  - 00 from D_PREP through TRAIL.
  - 11 otherwise.
- hs_clk_en = 1 from CLK_ZERO through CLK_TRAIL.
- hsxx_clk_en = 1 from CLK_PRE through CLK_POST.
- hs_data_en = 1 from D_ZERO through TRAIL.
- byte_D0:
  - 0x00 in D_ZERO.
  - 0xB8 in SYNC.
  - The accepted payload byte in DATA.
  - In TRAIL, {8{~b[7]}}, where b is the last byte driven in SYNC/DATA.
  - 0x00 elsewhere.
- s_ready = 1 in SYNC, and in DATA until a byte with s_last has been accepted.
  - A byte accepted at the edge ending cycle k appears on byte_D0 in cycle k+1, and the state is DATA.
- After the s_last byte is shown for its one cycle, DATA → TRAIL.
- Underflow: s_valid=0 while s_ready=1.
  - Next state is TRAIL, and err_underflow pulses for one cycle.
  - Trail polarity comes from the last byte driven, which is 0xB8 if the underflow happens in SYNC.
- A single-byte packet (s_last on the first byte) is legal and gives exactly one DATA cycle.
- s_valid/s_data/s_last are ignored outside SYNC/DATA.

## Timing
- Reset values:
  - lp0_out = lpclk_out = 11.
  - hs_data_en = hs_clk_en = hsxx_clk_en = 0.
  - byte_D0 = 0x00.
  - s_ready = busy = err_underflow = 0.
  - State IDLE, counter 0.
- Reset asserted mid-packet forces all reset values at the next edge; no trail is emitted.
- Latency with defaults, with s_valid rising in IDLE cycle 0:
  - CLK_LPX at cycles 1–2.
  - D_LPX at 15–16.
  - D_ZERO at 19–24.
  - SYNC at 25.
  - First payload byte on byte_D0 at 26.
- Packet of N bytes, no underflow:
  - DATA lasts N cycles.
  - TRAIL starts at 26+N.
  - IDLE is reached at 26+N+12 (T_HS_TRAIL + T_CLK_POST + T_CLK_TRAIL + T_LPX).
- s_valid held high in EXIT does not shorten EXIT. A new packet starts no earlier than the cycle after IDLE is entered.

## Structure
- Shared package `dphy_tx_pkg` holds:
  - The state enum.
  - SYNC_BYTE = 8'hB8.
  - LP code constants LP11 = 2'b11, LP01 = 2'b01, LP00 = 2'b00.
- One sub-module, `dphy_tx_timer`, is a loadable down-counter.
  - Inputs: load, value; output: zero.
  - Width is derived from the largest parameter.

## Test plan
- Reset held 3 cycles with s_valid=1 → all outputs at reset values, busy=0, and no state change until release.
- Defaults, 2-byte packet 0x12, 0x34 (s_last on 0x34) → byte_D0 shows:
  - 0x00 for cycles 19–24.
  - 0xB8 at 25.
  - 0x12 at 26.
  - 0x34 at 27.
  - 0xFF for cycles 28–31, since 0x34[7]=0.
  - Then: hs_data_en falls at 32, hsxx_clk_en falls at 36, lpclk_out=11 at 38, busy=0 at 40.
- Single byte 0x80 with s_last → one DATA cycle showing 0x80, then 4 trail bytes of 0x00.
- s_valid dropped after the first of 3 bytes (0xAA) → err_underflow pulses once, TRAIL follows immediately with 0x00 bytes, and the full exit sequence completes.
- Reset asserted during CLK_PRE → the next cycle shows lp outputs 11 and all HS enables 0, then a new packet runs a correct full sequence.
- Back-to-back packets with s_valid held high → the second packet's CLK_LPX starts only after 2 EXIT cycles plus 1 IDLE cycle; LP-11 is visible on both lanes for ≥2 cycles.

Source files
------------

// File: rtl/dphy_lane_sequencer_pkg.sv
// Shared types and constants for the D-PHY HS transmit lane sequencer.
package dphy_tx_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CLK_LPX,
        ST_CLK_PREP,
        ST_CLK_ZERO,
        ST_CLK_PRE,
        ST_D_LPX,
        ST_D_PREP,
        ST_D_ZERO,
        ST_SYNC,
        ST_DATA,
        ST_TRAIL,
        ST_CLK_POST,
        ST_CLK_TRAIL,
        ST_EXIT
    } tx_state_e;

    localparam logic [7:0] SYNC_BYTE = 8'hB8;
    localparam logic [1:0] LP11      = 2'b11;
    localparam logic [1:0] LP01      = 2'b01;
    localparam logic [1:0] LP00      = 2'b00;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/dphy_lane_sequencer_if.sv
// Payload byte stream into the lane sequencer (valid/ready with end-of-packet marker).
interface dphy_lane_sequencer_if;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_last;
    logic       s_ready;

    modport master (output s_valid, output s_data, output s_last, input  s_ready);
    modport slave  (input  s_valid, input  s_data, input  s_last, output s_ready);
endinterface

// File: rtl/dphy_lane_sequencer_timer.sv
// Loadable down-counter shared by all timed sequencer states; zero flags expiry.
module dphy_tx_timer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             byte_clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    output logic             zero
);
    logic [WIDTH-1:0] cnt;

    always_ff @(posedge byte_clk) begin
        if (reset)
            cnt <= '0;
        else if (load)
            cnt <= value;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);
endmodule

// File: rtl/dphy_lane_sequencer.sv
// Byte-clock sequencer driving clock/data lane LP states, HS enables and HS bytes
// for one packet at a time through a single-lane D-PHY transmitter.
module dphy_lane_sequencer
    import dphy_tx_pkg::*;
#(
    parameter int unsigned T_LPX       = 2,
    parameter int unsigned T_HS_PREP   = 2,
    parameter int unsigned T_CLK_ZERO  = 8,
    parameter int unsigned T_CLK_PRE   = 2,
    parameter int unsigned T_HS_ZERO   = 6,
    parameter int unsigned T_HS_TRAIL  = 4,
    parameter int unsigned T_CLK_POST  = 4,
    parameter int unsigned T_CLK_TRAIL = 2
) (
    input  logic                        byte_clk,
    input  logic                        reset,
    dphy_lane_sequencer_if.slave        sif,
    output logic [7:0]                  byte_D0,
    output logic                        hs_data_en,
    output logic                        hs_clk_en,
    output logic                        hsxx_clk_en,
    output logic [1:0]                  lp0_out,
    output logic [1:0]                  lpclk_out,
    output logic                        busy,
    output logic                        err_underflow
);
    localparam int unsigned T_MAX = max_u(max_u(max_u(T_LPX, T_HS_PREP), max_u(T_CLK_ZERO, T_CLK_PRE)),
                                          max_u(max_u(T_HS_ZERO, T_HS_TRAIL), max_u(T_CLK_POST, T_CLK_TRAIL)));
    localparam int unsigned CW = $clog2(T_MAX + 1);

    tx_state_e   state, state_n;
    logic        tmr_load, tmr_zero, underflow;
    logic [CW-1:0] tmr_val;
    logic        s_ready_q, s_ready_n;
    logic [7:0]  byte_n;

    dphy_tx_timer #(.WIDTH(CW)) u_timer (
        .byte_clk (byte_clk),
        .reset    (reset),
        .load     (tmr_load),
        .value    (tmr_val),
        .zero     (tmr_zero)
    );

    always_ff @(posedge byte_clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            byte_D0       <= '0;
            hs_data_en    <= 1'b0;
            hs_clk_en     <= 1'b0;
            hsxx_clk_en   <= 1'b0;
            lp0_out       <= LP11;
            lpclk_out     <= LP11;
            busy          <= 1'b0;
            err_underflow <= 1'b0;
            s_ready_q     <= 1'b0;
        end else begin
            state         <= state_n;
            byte_D0       <= byte_n;
            hs_data_en    <= state_n inside {ST_D_ZERO, ST_SYNC, ST_DATA, ST_TRAIL};
            hs_clk_en     <= state_n inside {[ST_CLK_ZERO:ST_CLK_TRAIL]};
            hsxx_clk_en   <= state_n inside {[ST_CLK_PRE:ST_CLK_POST]};
            lp0_out       <= (state_n == ST_D_LPX) ? LP01 :
                             (state_n inside {[ST_D_PREP:ST_TRAIL]}) ? LP00 : LP11;
            lpclk_out     <= (state_n == ST_CLK_LPX) ? LP01 :
                             (state_n inside {ST_IDLE, ST_EXIT}) ? LP11 : LP00;
            busy          <= (state_n != ST_IDLE);
            err_underflow <= underflow;
            s_ready_q     <= s_ready_n;
        end
    end

    assign sif.s_ready = s_ready_q;

    // Outputs are registered from the next state so they line up with the state they describe.
    always_comb begin
        state_n   = state;
        underflow = 1'b0;
        unique case (state)
            ST_IDLE:      if (sif.s_valid) state_n = ST_CLK_LPX;
            ST_CLK_LPX:   if (tmr_zero) state_n = ST_CLK_PREP;
            ST_CLK_PREP:  if (tmr_zero) state_n = ST_CLK_ZERO;
            ST_CLK_ZERO:  if (tmr_zero) state_n = ST_CLK_PRE;
            ST_CLK_PRE:   if (tmr_zero) state_n = ST_D_LPX;
            ST_D_LPX:     if (tmr_zero) state_n = ST_D_PREP;
            ST_D_PREP:    if (tmr_zero) state_n = ST_D_ZERO;
            ST_D_ZERO:    if (tmr_zero) state_n = ST_SYNC;
            ST_SYNC, ST_DATA: begin
                if (!s_ready_q)
                    state_n = ST_TRAIL;
                else if (sif.s_valid)
                    state_n = ST_DATA;
                else begin
                    state_n   = ST_TRAIL;
                    underflow = 1'b1;
                end
            end
            ST_TRAIL:     if (tmr_zero) state_n = ST_CLK_POST;
            ST_CLK_POST:  if (tmr_zero) state_n = ST_CLK_TRAIL;
            ST_CLK_TRAIL: if (tmr_zero) state_n = ST_EXIT;
            ST_EXIT:      if (tmr_zero) state_n = ST_IDLE;
            default:      state_n = ST_IDLE;
        endcase

        tmr_load = (state_n != state);
        unique case (state_n)
            ST_CLK_LPX, ST_D_LPX, ST_EXIT: tmr_val = CW'(T_LPX - 1);
            ST_CLK_PREP, ST_D_PREP:        tmr_val = CW'(T_HS_PREP - 1);
            ST_CLK_ZERO:                   tmr_val = CW'(T_CLK_ZERO - 1);
            ST_CLK_PRE:                    tmr_val = CW'(T_CLK_PRE - 1);
            ST_D_ZERO:                     tmr_val = CW'(T_HS_ZERO - 1);
            ST_TRAIL:                      tmr_val = CW'(T_HS_TRAIL - 1);
            ST_CLK_POST:                   tmr_val = CW'(T_CLK_POST - 1);
            ST_CLK_TRAIL:                  tmr_val = CW'(T_CLK_TRAIL - 1);
            default:                       tmr_val = '0;
        endcase

        // Entering DATA always means a byte was just accepted, so s_last belongs to it.
        s_ready_n = (state_n == ST_SYNC) || ((state_n == ST_DATA) && !sif.s_last);

        // Trail polarity is frozen on entry from whatever byte was last on the lane.
        unique case (state_n)
            ST_SYNC:  byte_n = SYNC_BYTE;
            ST_DATA:  byte_n = sif.s_data;
            ST_TRAIL: byte_n = (state == ST_TRAIL) ? byte_D0 : {8{~byte_D0[7]}};
            default:  byte_n = 8'h00;
        endcase
    end
endmodule

// File: tb/tb_dphy_lane_sequencer.sv
// Directed bench for dphy_lane_sequencer: per-cycle trace of each packet checked against hand-derived timing.
module tb_dphy_lane_sequencer;
    logic       byte_clk = 1'b0;
    logic       reset;
    logic [7:0] byte_D0;
    logic       hs_data_en, hs_clk_en, hsxx_clk_en, busy, err_underflow;
    logic [1:0] lp0_out, lpclk_out;

    dphy_lane_sequencer_if sif ();

    dphy_lane_sequencer dut (
        .byte_clk      (byte_clk),
        .reset         (reset),
        .sif           (sif.slave),
        .byte_D0       (byte_D0),
        .hs_data_en    (hs_data_en),
        .hs_clk_en     (hs_clk_en),
        .hsxx_clk_en   (hsxx_clk_en),
        .lp0_out       (lp0_out),
        .lpclk_out     (lpclk_out),
        .busy          (busy),
        .err_underflow (err_underflow)
    );

    always #5 byte_clk = ~byte_clk;

    typedef struct packed {
        logic [7:0] b;
        logic       hsd, hsc, hsxx;
        logic [1:0] lp0, lpc;
        logic       bsy, err, rdy;
    } obs_t;

    obs_t       tr [64];
    logic [7:0] pkt [4];
    int         n_tests = 0;
    int         n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic obs_t sample();
        obs_t o;
        o.b = byte_D0; o.hsd = hs_data_en; o.hsc = hs_clk_en; o.hsxx = hsxx_clk_en;
        o.lp0 = lp0_out; o.lpc = lpclk_out; o.bsy = busy; o.err = err_underflow; o.rdy = sif.s_ready;
        return o;
    endfunction

    // Cycle 0 is the IDLE cycle in which s_valid first rises; tr[k] is sampled mid-cycle k.
    task automatic run_pkt(input int n_pkt, input int n_send, input logic hold, input int n_cyc);
        int   idx = 0;
        logic rdy_prev;
        @(negedge byte_clk);
        sif.s_valid = 1'b1; sif.s_data = pkt[0]; sif.s_last = (n_pkt == 1);
        tr[0] = sample(); rdy_prev = sif.s_ready;
        for (int k = 1; k <= n_cyc; k++) begin
            @(posedge byte_clk);
            if (rdy_prev && sif.s_valid) idx++;
            #1;
            if (idx < n_send) begin
                sif.s_valid = 1'b1; sif.s_data = pkt[idx]; sif.s_last = (idx == n_pkt - 1);
            end else if (hold) begin
                sif.s_valid = 1'b1; sif.s_data = 8'h66; sif.s_last = 1'b1;
            end else begin
                sif.s_valid = 1'b0; sif.s_last = 1'b0;
            end
            @(negedge byte_clk);
            tr[k] = sample(); rdy_prev = sif.s_ready;
        end
    endtask

    function automatic int err_count(input int n_cyc);
        int e = 0;
        for (int k = 0; k <= n_cyc; k++) e += int'(tr[k].err);
        return e;
    endfunction

    // 2-byte packet 0x12, 0x34 with default timing.
    task automatic check_two(input string p);
        check({p, "_busy0"}, 32'(tr[0].bsy), 0);
        check({p, "_lpc_lpx"}, 32'(tr[1].lpc), 'b01);
        check({p, "_lpc_prep"}, 32'(tr[3].lpc), 'b00);
        check({p, "_hsc4"}, 32'(tr[4].hsc), 0);
        check({p, "_hsc5"}, 32'(tr[5].hsc), 1);
        check({p, "_hsxx12"}, 32'(tr[12].hsxx), 0);
        check({p, "_hsxx13"}, 32'(tr[13].hsxx), 1);
        check({p, "_lp0_14"}, 32'(tr[14].lp0), 'b11);
        check({p, "_lp0_15"}, 32'(tr[15].lp0), 'b01);
        check({p, "_lp0_17"}, 32'(tr[17].lp0), 'b00);
        check({p, "_hsd18"}, 32'(tr[18].hsd), 0);
        for (int k = 19; k <= 24; k++) check({p, "_hszero"}, 32'(tr[k].b), 'h00);
        for (int k = 19; k <= 31; k++) check({p, "_hsd_on"}, 32'(tr[k].hsd), 1);
        check({p, "_rdy24"}, 32'(tr[24].rdy), 0);
        check({p, "_sync"}, 32'(tr[25].b), 'hB8);
        check({p, "_rdy25"}, 32'(tr[25].rdy), 1);
        check({p, "_b0"}, 32'(tr[26].b), 'h12);
        check({p, "_rdy26"}, 32'(tr[26].rdy), 1);
        check({p, "_b1"}, 32'(tr[27].b), 'h34);
        check({p, "_rdy27"}, 32'(tr[27].rdy), 0);
        for (int k = 28; k <= 31; k++) check({p, "_trail"}, 32'(tr[k].b), 'hFF);
        check({p, "_hsd32"}, 32'(tr[32].hsd), 0);
        check({p, "_b32"}, 32'(tr[32].b), 'h00);
        check({p, "_lp0_32"}, 32'(tr[32].lp0), 'b11);
        check({p, "_hsxx35"}, 32'(tr[35].hsxx), 1);
        check({p, "_hsxx36"}, 32'(tr[36].hsxx), 0);
        check({p, "_hsc37"}, 32'(tr[37].hsc), 1);
        check({p, "_lpc37"}, 32'(tr[37].lpc), 'b00);
        check({p, "_lpc38"}, 32'(tr[38].lpc), 'b11);
        check({p, "_hsc38"}, 32'(tr[38].hsc), 0);
        check({p, "_busy39"}, 32'(tr[39].bsy), 1);
        check({p, "_busy40"}, 32'(tr[40].bsy), 0);
        check({p, "_errs"}, 32'(err_count(42)), 0);
    endtask

    initial begin
        reset = 1'b1;
        sif.s_valid = 1'b1; sif.s_data = 8'h5A; sif.s_last = 1'b0;

        // Reset held with s_valid high: everything stays at reset values.
        repeat (3) begin
            @(negedge byte_clk);
            check("rst_lp0", 32'(lp0_out), 'b11);
            check("rst_lpc", 32'(lpclk_out), 'b11);
            check("rst_hs", {29'd0, hs_data_en, hs_clk_en, hsxx_clk_en}, 0);
            check("rst_byte", 32'(byte_D0), 'h00);
            check("rst_busy", 32'(busy), 0);
            check("rst_rdy", 32'(sif.s_ready), 0);
            check("rst_err", 32'(err_underflow), 0);
        end
        reset = 1'b0; sif.s_valid = 1'b0;
        repeat (2) @(negedge byte_clk);
        check("idle_busy", 32'(busy), 0);

        pkt[0] = 8'h12; pkt[1] = 8'h34;
        run_pkt(2, 2, 1'b0, 42);
        check_two("A");

        // Single byte 0x80: one DATA cycle, trail of 0x00.
        pkt[0] = 8'h80;
        run_pkt(1, 1, 1'b0, 42);
        check("B_sync", 32'(tr[25].b), 'hB8);
        check("B_data", 32'(tr[26].b), 'h80);
        check("B_rdy26", 32'(tr[26].rdy), 0);
        for (int k = 27; k <= 30; k++) check("B_trail", 32'(tr[k].b), 'h00);
        check("B_hsd30", 32'(tr[30].hsd), 1);
        check("B_hsd31", 32'(tr[31].hsd), 0);
        check("B_busy38", 32'(tr[38].bsy), 1);
        check("B_busy39", 32'(tr[39].bsy), 0);
        check("B_errs", 32'(err_count(42)), 0);

        // Underflow: only 0xAA of a 3-byte packet is offered.
        pkt[0] = 8'hAA; pkt[1] = 8'hBB; pkt[2] = 8'hCC;
        run_pkt(3, 1, 1'b0, 42);
        check("C_data", 32'(tr[26].b), 'hAA);
        check("C_err26", 32'(tr[26].err), 0);
        check("C_err27", 32'(tr[27].err), 1);
        check("C_errs", 32'(err_count(42)), 1);
        for (int k = 27; k <= 30; k++) check("C_trail", 32'(tr[k].b), 'h00);
        check("C_rdy27", 32'(tr[27].rdy), 0);
        check("C_hsd31", 32'(tr[31].hsd), 0);
        check("C_hsxx34", 32'(tr[34].hsxx), 1);
        check("C_hsxx35", 32'(tr[35].hsxx), 0);
        check("C_lpc37", 32'(tr[37].lpc), 'b11);
        check("C_busy38", 32'(tr[38].bsy), 1);
        check("C_busy39", 32'(tr[39].bsy), 0);

        // Reset during CLK_PRE (cycles 13-14).
        @(negedge byte_clk);
        sif.s_valid = 1'b1; sif.s_data = 8'h11; sif.s_last = 1'b1;
        repeat (13) @(posedge byte_clk);
        @(negedge byte_clk);
        check("D_pre_hsxx", 32'(hsxx_clk_en), 1);
        reset = 1'b1;
        @(negedge byte_clk);
        check("D_lp0", 32'(lp0_out), 'b11);
        check("D_lpc", 32'(lpclk_out), 'b11);
        check("D_hs", {29'd0, hs_data_en, hs_clk_en, hsxx_clk_en}, 0);
        check("D_busy", 32'(busy), 0);
        reset = 1'b0; sif.s_valid = 1'b0;
        repeat (3) @(negedge byte_clk);
        pkt[0] = 8'h12; pkt[1] = 8'h34;
        run_pkt(2, 2, 1'b0, 42);
        check_two("D");

        // Back-to-back: s_valid stays high into the next packet.
        pkt[0] = 8'h55;
        run_pkt(1, 1, 1'b1, 44);
        for (int k = 37; k <= 39; k++) begin
            check("E_lpc11", 32'(tr[k].lpc), 'b11);
            check("E_lp011", 32'(tr[k].lp0), 'b11);
        end
        check("E_busy38", 32'(tr[38].bsy), 1);
        check("E_busy39", 32'(tr[39].bsy), 0);
        check("E_busy40", 32'(tr[40].bsy), 1);
        check("E_lpc40", 32'(tr[40].lpc), 'b01);
        check("E_lpc42", 32'(tr[42].lpc), 'b00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
